// File: rtl/mem16_responder.sv
// -----------------------------------------------------------------------------
// mem16_responder
//   Word-addressed RAM/ROM responder for a 16-bit CPU with a DMA side port.
//   The CPU reads every cycle with one cycle of latency. The DMA port gets
//   the bus through a hold/busy handshake with the CPU.
//
//   Memory map (aliased):
//     addr[15] = 0 : RAM[addr[RAM_AW-1:0]]  (CPU and DMA read/write)
//     addr[15] = 1 : ROM[addr[ROM_AW-1:0]]  (CPU read-only, DMA read/write)
//
//   Ports:
//     clk        in   rising-edge clock
//     reset      in   synchronous active-high reset
//     address    in   CPU word address
//     from_cpu   in   CPU write data
//     write      in   CPU write strobe
//     to_cpu     out  CPU read data, registered (read-before-write)
//     hold       out  bus-stall request to the CPU
//     busy       in   CPU stalled / bus released acknowledge
//     dma_req    in   DMA requests the bus; one access per GRANT cycle
//     dma_addr   in   DMA word address
//     dma_wdata  in   DMA write data
//     dma_we     in   DMA write (1) / read (0)
//     dma_ack    out  one-cycle pulse the cycle after each DMA access
//     dma_rdata  out  DMA read data, valid with dma_ack, held otherwise
//
//   Arbiter states:
//     state     | meaning
//     ----------+------------------------------------------------------------
//     S_IDLE    | CPU owns the bus, hold=0
//     S_REQ     | hold=1, waiting for busy; CPU still serviced
//     S_GRANT   | hold=1, DMA owns the bus; CPU writes blocked
//     S_RELEASE | hold=0 for one cycle, no DMA access, then IDLE
// -----------------------------------------------------------------------------
module mem16_responder #(
    parameter int RAM_AW = 12,
    parameter int ROM_AW = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [15:0] from_cpu,
    input  logic        write,
    output logic [15:0] to_cpu,
    output logic        hold,
    input  logic        busy,
    input  logic        dma_req,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata,
    input  logic        dma_we,
    output logic        dma_ack,
    output logic [15:0] dma_rdata
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_GRANT   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [15:0] ram_q [2**RAM_AW];
    logic [15:0] rom_q [2**ROM_AW];

    logic [15:0] to_cpu_q;
    logic        dma_ack_q;
    logic [15:0] dma_rdata_q;

    logic        dma_go;
    logic        cpu_ram_we;
    logic        dma_ram_we;
    logic        dma_rom_we;
    logic [15:0] cpu_rd_word;
    logic [15:0] dma_rd_word;

    // Address bits above the aliased windows are intentionally ignored.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^{address, dma_addr};

    // Nothing in a reset cycle touches memory.
    assign dma_go     = (state_q == S_GRANT) && dma_req && !reset;
    assign cpu_ram_we = write && !address[15] && (state_q != S_GRANT) && !reset;
    assign dma_ram_we = dma_go && dma_we && !dma_addr[15];
    assign dma_rom_we = dma_go && dma_we && dma_addr[15];

    assign cpu_rd_word = address[15] ? rom_q[address[ROM_AW-1:0]]
                                     : ram_q[address[RAM_AW-1:0]];
    assign dma_rd_word = dma_addr[15] ? rom_q[dma_addr[ROM_AW-1:0]]
                                      : ram_q[dma_addr[RAM_AW-1:0]];

    // CPU and DMA writes are exclusive: CPU writes are blocked in GRANT,
    // and DMA only accesses in GRANT.
    always_ff @(posedge clk) begin
        if (cpu_ram_we) begin
            ram_q[address[RAM_AW-1:0]] <= from_cpu;
        end else if (dma_ram_we) begin
            ram_q[dma_addr[RAM_AW-1:0]] <= dma_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (dma_rom_we) begin
            rom_q[dma_addr[ROM_AW-1:0]] <= dma_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            to_cpu_q    <= 16'h0000;
            dma_ack_q   <= 1'b0;
            dma_rdata_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            to_cpu_q  <= cpu_rd_word;
            dma_ack_q <= dma_go;
            if (dma_go && !dma_we) begin
                dma_rdata_q <= dma_rd_word;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        hold    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dma_req) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                hold = 1'b1;
                // A withdrawn request wins over a late busy.
                if (!dma_req) begin
                    state_d = S_IDLE;
                end else if (busy) begin
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                hold = 1'b1;
                // busy is not consulted here: hold alone keeps the CPU stalled.
                if (!dma_req) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign to_cpu    = to_cpu_q;
    assign dma_ack   = dma_ack_q;
    assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_mem16_responder.sv
// -----------------------------------------------------------------------------
// tb_mem16_responder
//   Self-checking bench for mem16_responder: reset values, directed bus
//   handshake sequences, a table of CPU read/write vectors, and randomized
//   CPU/DMA traffic checked against plain RAM/ROM arrays.
// -----------------------------------------------------------------------------
module tb_mem16_responder;

    localparam int RAM_AW = 12;
    localparam int ROM_AW = 8;

    logic        clk;
    logic        reset;
    logic [15:0] address;
    logic [15:0] from_cpu;
    logic        write;
    logic [15:0] to_cpu;
    logic        hold;
    logic        busy;
    logic        dma_req;
    logic [15:0] dma_addr;
    logic [15:0] dma_wdata;
    logic        dma_we;
    logic        dma_ack;
    logic [15:0] dma_rdata;

    mem16_responder #(.RAM_AW(RAM_AW), .ROM_AW(ROM_AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .from_cpu  (from_cpu),
        .write     (write),
        .to_cpu    (to_cpu),
        .hold      (hold),
        .busy      (busy),
        .dma_req   (dma_req),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_we    (dma_we),
        .dma_ack   (dma_ack),
        .dma_rdata (dma_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference memory image.
    logic [15:0] ram_m [2**RAM_AW];
    logic [15:0] rom_m [2**ROM_AW];
    logic [15:0] exp_rdata;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        wr;
        bit          chk;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [11];

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mread(input logic [15:0] a);
        if (a[15]) return rom_m[a[ROM_AW-1:0]];
        return ram_m[a[RAM_AW-1:0]];
    endfunction

    task automatic mwrite(input logic [15:0] a, input logic [15:0] d);
        if (a[15]) rom_m[a[ROM_AW-1:0]] = d;
        else       ram_m[a[RAM_AW-1:0]] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One CPU cycle outside GRANT: reads return the pre-write word, ROM ignores writes.
    task automatic cpu_op(input logic [15:0] a, input logic [15:0] d, input logic wr, input bit do_chk);
        logic [15:0] e;
        e        = mread(a);
        address  = a;
        from_cpu = d;
        write    = wr;
        if (wr && !a[15]) mwrite(a, d);
        tick();
        write = 1'b0;
        if (do_chk) chk16("cpu_to_cpu", to_cpu, e);
    endtask

    task automatic dma_enter(input int dly);
        write   = 1'b0;
        busy    = 1'b0;
        dma_req = 1'b1;
        tick();
        chk1("hold_in_req", hold, 1'b1);
        repeat (dly) begin
            tick();
            chk1("hold_wait_busy", hold, 1'b1);
        end
        busy = 1'b1;
        tick();
        chk1("hold_in_grant", hold, 1'b1);
        chk1("ack_before_access", dma_ack, 1'b0);
    endtask

    // One DMA access in GRANT with concurrent CPU traffic (CPU writes must be dropped).
    task automatic dma_access(input logic [15:0] a, input logic [15:0] d, input logic we,
                              input logic [15:0] ca, input logic [15:0] cd, input logic cwr);
        logic [15:0] e_dma;
        logic [15:0] e_cpu;
        e_dma     = mread(a);
        e_cpu     = mread(ca);
        dma_addr  = a;
        dma_wdata = d;
        dma_we    = we;
        address   = ca;
        from_cpu  = cd;
        write     = cwr;
        if (we) mwrite(a, d);
        else    exp_rdata = e_dma;
        tick();
        chk1("dma_ack_pulse", dma_ack, 1'b1);
        if (!we) chk16("dma_rdata", dma_rdata, e_dma);
        chk16("to_cpu_in_grant", to_cpu, e_cpu);
    endtask

    task automatic dma_exit();
        dma_req = 1'b0;
        busy    = 1'b0;
        dma_we  = 1'b0;
        write   = 1'b0;
        tick();
        chk1("hold_release", hold, 1'b0);
        chk1("ack_release", dma_ack, 1'b0);
        chk16("rdata_held", dma_rdata, exp_rdata);
        tick();
        chk1("hold_idle", hold, 1'b0);
        chk1("ack_idle", dma_ack, 1'b0);
    endtask

    initial begin
        vecs[0]  = '{16'h0042, 16'h1234, 1'b1, 1'b0, 16'h0000};
        vecs[1]  = '{16'h0042, 16'h0000, 1'b0, 1'b1, 16'h1234};
        vecs[2]  = '{16'h0042, 16'h0000, 1'b0, 1'b1, 16'h1234};
        vecs[3]  = '{16'h1042, 16'h0000, 1'b0, 1'b1, 16'h1234};
        vecs[4]  = '{16'h8005, 16'hBEEF, 1'b1, 1'b1, 16'hC005};
        vecs[5]  = '{16'h8005, 16'h0000, 1'b0, 1'b1, 16'hC005};
        vecs[6]  = '{16'h8002, 16'h0000, 1'b0, 1'b1, 16'hA002};
        vecs[7]  = '{16'h0010, 16'h0000, 1'b0, 1'b1, 16'h0001};
        vecs[8]  = '{16'h0042, 16'h5678, 1'b1, 1'b1, 16'h1234};
        vecs[9]  = '{16'h7042, 16'h0000, 1'b0, 1'b1, 16'h5678};
        vecs[10] = '{16'h8105, 16'h0000, 1'b0, 1'b1, 16'hC005};

        reset     = 1'b1;
        address   = 16'h0000;
        from_cpu  = 16'h0000;
        write     = 1'b0;
        busy      = 1'b0;
        dma_req   = 1'b0;
        dma_addr  = 16'h0000;
        dma_wdata = 16'h0000;
        dma_we    = 1'b0;
        exp_rdata = 16'h0000;

        tick();
        tick();
        chk1("reset_hold", hold, 1'b0);
        chk1("reset_ack", dma_ack, 1'b0);
        chk16("reset_to_cpu", to_cpu, 16'h0000);
        chk16("reset_rdata", dma_rdata, 16'h0000);
        reset = 1'b0;

        // Preload: RAM through the CPU, ROM through DMA.
        for (int i = 0; i < 2**RAM_AW; i++) cpu_op(16'(i), 16'($urandom), 1'b1, 1'b0);
        dma_enter(0);
        for (int i = 0; i < 2**ROM_AW; i++)
            dma_access(16'h8000 | 16'(i), 16'hC000 + 16'(i), 1'b1, 16'h0000, 16'h0000, 1'b0);
        dma_exit();

        // Request held off by busy=0 for 5 cycles; CPU write lands meanwhile.
        busy    = 1'b0;
        dma_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                address  = 16'h0010;
                from_cpu = 16'h0001;
                write    = 1'b1;
                mwrite(16'h0010, 16'h0001);
            end
            tick();
            write = 1'b0;
            chk1("req_hold_no_busy", hold, 1'b1);
        end
        busy = 1'b1;
        tick();
        chk1("grant_hold", hold, 1'b1);
        for (int i = 0; i < 4; i++)
            dma_access(16'h8000 + 16'(i), 16'hA000 + 16'(i), 1'b1, 16'h0010, 16'h0000, 1'b0);
        dma_access(16'h8002, 16'h0000, 1'b0, 16'h0010, 16'h0000, 1'b0);
        chk16("rom_dma_readback", dma_rdata, 16'hA002);
        dma_exit();

        // CPU vector table.
        for (int i = 0; i < 11; i++) begin
            address  = vecs[i].addr;
            from_cpu = vecs[i].wdata;
            write    = vecs[i].wr;
            if (vecs[i].wr && !vecs[i].addr[15]) mwrite(vecs[i].addr, vecs[i].wdata);
            tick();
            write = 1'b0;
            if (vecs[i].chk) chk16($sformatf("vec%0d_to_cpu", i), to_cpu, vecs[i].exp);
        end

        // Request withdrawn while in REQ.
        dma_req = 1'b1;
        tick();
        chk1("abandon_hold_req", hold, 1'b1);
        dma_req = 1'b0;
        tick();
        chk1("abandon_hold_drop", hold, 1'b0);
        chk1("abandon_no_ack", dma_ack, 1'b0);

        // Re-request during RELEASE: two hold=0 cycles before REQ.
        dma_enter(1);
        dma_access(16'h0100, 16'h1111, 1'b1, 16'h0000, 16'h0000, 1'b0);
        dma_req = 1'b0;
        busy    = 1'b0;
        dma_we  = 1'b0;
        tick();
        chk1("rereq_release_hold", hold, 1'b0);
        dma_req = 1'b1;
        tick();
        chk1("rereq_idle_hold", hold, 1'b0);
        chk1("rereq_idle_ack", dma_ack, 1'b0);
        tick();
        chk1("rereq_req_hold", hold, 1'b1);
        busy = 1'b1;
        tick();
        dma_access(16'h0100, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        chk16("rereq_readback", dma_rdata, 16'h1111);
        dma_exit();

        // busy falls mid-GRANT; CPU write during GRANT must be dropped.
        dma_enter(0);
        dma_access(16'h0120, 16'h5A5A, 1'b1, 16'h0020, 16'hDEAD, 1'b1);
        busy = 1'b0;
        dma_access(16'h0120, 16'h0000, 1'b0, 16'h0020, 16'hDEAD, 1'b1);
        dma_access(16'h0020, 16'h0000, 1'b0, 16'h0020, 16'hDEAD, 1'b1);
        chk1("busy_drop_hold", hold, 1'b1);
        dma_exit();
        cpu_op(16'h0020, 16'h0000, 1'b0, 1'b1);

        // Reset in the second GRANT cycle.
        dma_enter(0);
        dma_access(16'h0200, 16'h2222, 1'b1, 16'h0000, 16'h0000, 1'b0);
        reset     = 1'b1;
        dma_addr  = 16'h0201;
        dma_wdata = 16'h3333;
        dma_we    = 1'b1;
        address   = 16'h0300;
        from_cpu  = 16'h4444;
        write     = 1'b1;
        tick();
        chk1("rst_grant_hold", hold, 1'b0);
        chk1("rst_grant_ack", dma_ack, 1'b0);
        chk16("rst_grant_to_cpu", to_cpu, 16'h0000);
        chk16("rst_grant_rdata", dma_rdata, 16'h0000);
        exp_rdata = 16'h0000;
        reset   = 1'b0;
        dma_req = 1'b0;
        busy    = 1'b0;
        dma_we  = 1'b0;
        write   = 1'b0;
        cpu_op(16'h0200, 16'h0000, 1'b0, 1'b1);
        chk16("rst_persist_write", to_cpu, 16'h2222);
        cpu_op(16'h0201, 16'h0000, 1'b0, 1'b1);
        cpu_op(16'h0300, 16'h0000, 1'b0, 1'b1);

        // Randomized traffic.
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 9) < 7) begin
                cpu_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
            end else begin
                dma_enter(int'($urandom_range(0, 3)));
                for (int k = 0; k < int'($urandom_range(1, 8)); k++)
                    dma_access(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                               16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
                dma_exit();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
